// File: rtl/rex_game_ctrl.sv
// rex_game_ctrl
// -------------
// Game-logic controller for the Rex runner. Advances the game by one step on
// every frame tick and holds the registered game variables that the renderer
// reads: rex height, obstacle column, game state and score. Sequences
// IDLE -> RUN -> OVER -> IDLE, runs the jump arc, scrolls the obstacle,
// detects collisions and counts completed RUN ticks.
//
// Optional feature macro: REX_SPEEDUP_EN
//   defined   : obstacle speed rises by one every 64 points, capped at MAX_SPEED.
//   undefined : obstacle speed is the constant SPEED.
//
// Ports
//   clk            in   system clock (120 kHz)
//   rstn           in   asynchronous active-low reset
//   tick_i         in   frame-step pulse, one clk wide, synchronous to clk
//   jump_i         in   jump/start button, asynchronous level
//   rex_down       out  [15:0] rex height above ground in pixels, 0 = ground
//   obstacle_left  out  [15:0] obstacle left-edge column
//   game_state     out  [1:0]  00 IDLE, 01 RUN, 10 OVER (11 never driven)
//   score_o        out  [15:0] completed RUN ticks, saturating
module rex_game_ctrl #(
  parameter int SCREEN_W  = 128,
  parameter int SPEED     = 2,
  parameter int MAX_SPEED = 6,
  parameter int REX_X     = 8,
  parameter int REX_W     = 16,
  parameter int OBST_W    = 4,
  parameter int OBST_H    = 16,
  parameter int JUMP_PEAK = 6,
  parameter int JUMP_STEP = 8
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        tick_i,
  input  logic        jump_i,
  output logic [15:0] rex_down,
  output logic [15:0] obstacle_left,
  output logic [1:0]  game_state,
  output logic [15:0] score_o
);

  localparam int DATA_W = 16;
  // Speed register wide enough for whichever of base/ceiling is larger.
  localparam int SPD_W  = $clog2(((MAX_SPEED > SPEED) ? MAX_SPEED : SPEED) + 1);

  localparam logic [DATA_W-1:0] SCREEN_V  = DATA_W'(SCREEN_W);
  localparam logic [DATA_W-1:0] HIT_RIGHT = DATA_W'(REX_X + REX_W);
  localparam logic [DATA_W:0]   HIT_LEFT  = (DATA_W+1)'(REX_X);
  localparam logic [DATA_W:0]   OBST_W_V  = (DATA_W+1)'(OBST_W);
  localparam logic [DATA_W-1:0] OBST_H_V  = DATA_W'(OBST_H);
  localparam logic [DATA_W-1:0] STEP_V    = DATA_W'(JUMP_STEP);
  localparam logic [DATA_W-1:0] APEX2_V   = DATA_W'(2 * JUMP_PEAK);
  localparam logic [4:0]        PHASE_END = 5'(2 * JUMP_PEAK);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_OVER = 2'b10
  } state_t;

  // Score increment that sticks at all-ones instead of wrapping.
  function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
    return (v == {DATA_W{1'b1}}) ? v : v + DATA_W'(1);
  endfunction

  // Triangular jump arc: JUMP_STEP * min(phase, 2*JUMP_PEAK - phase).
  // Phase never exceeds 2*JUMP_PEAK, so the falling leg cannot underflow.
  function automatic logic [DATA_W-1:0] jump_height(input logic [4:0] ph);
    logic [DATA_W-1:0] up;
    logic [DATA_W-1:0] down;
    logic [DATA_W-1:0] m;
    up   = DATA_W'(ph);
    down = APEX2_V - up;
    m    = (up < down) ? up : down;
    return m * STEP_V;
  endfunction

  state_t            state, state_n;
  logic [4:0]        phase, phase_n;
  logic [DATA_W-1:0] rex_n, obst_n, score_n;
  logic [SPD_W-1:0]  spd;

  logic              sync_p0, sync_p1, sync_p2;
  logic              btn_edge;
  logic              press;

  logic [DATA_W-1:0] obst_step;
  logic [4:0]        phase_step;
  logic [DATA_W-1:0] rex_step;
  logic [DATA_W-1:0] score_inc;
  logic              hit;

  // ---- stage: button synchronizer and rising-edge detect ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sync_p0 <= 1'b0;
      sync_p1 <= 1'b0;
      sync_p2 <= 1'b0;
    end else begin
      sync_p0 <= jump_i;
      sync_p1 <= sync_p0;
      sync_p2 <= sync_p1;
    end
  end

  assign btn_edge = sync_p1 & ~sync_p2;

  // A tick consumes the pending press; an edge seen on the tick cycle itself
  // is kept for the following tick.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      press <= 1'b0;
    end else if (tick_i) begin
      press <= btn_edge;
    end else if (btn_edge) begin
      press <= 1'b1;
    end
  end

  // ---- stage: candidate RUN-step values (evaluated every cycle) ----
  assign obst_step = (obstacle_left < DATA_W'(spd)) ? SCREEN_V
                                                    : obstacle_left - DATA_W'(spd);

  always_comb begin
    phase_step = phase;
    if (phase == 5'd0) begin
      phase_step = press ? 5'd1 : 5'd0;
    end else if (phase == PHASE_END) begin
      phase_step = 5'd0;
    end else begin
      phase_step = phase + 5'd1;
    end
  end

  assign rex_step  = jump_height(phase_step);
  assign score_inc = sat_inc(score_o);

  // Collision uses the post-step (possibly wrapped) positions; the right-edge
  // sum is one bit wider so it cannot wrap.
  assign hit = (obst_step < HIT_RIGHT) &&
               (({1'b0, obst_step} + OBST_W_V) > HIT_LEFT) &&
               (rex_step < OBST_H_V);

  // ---- stage: speed ----
`ifdef REX_SPEEDUP_EN
  logic spd_up;

  assign spd_up = tick_i && (state == ST_RUN) && !hit &&
                  (score_inc[5:0] == 6'd0) && (spd < SPD_W'(MAX_SPEED));

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      spd <= SPD_W'(SPEED);
    end else if (tick_i && (state == ST_OVER) && press) begin
      spd <= SPD_W'(SPEED);
    end else if (spd_up) begin
      spd <= spd + SPD_W'(1);
    end
  end
`else
  assign spd = SPD_W'(SPEED);
`endif

  // ---- stage: next-state / next-output selection ----
  always_comb begin
    state_n = state;
    phase_n = phase;
    rex_n   = rex_down;
    obst_n  = obstacle_left;
    score_n = score_o;
    if (tick_i) begin
      case (state)
        ST_IDLE: begin
          if (press) begin
            state_n = ST_RUN;
          end
        end
        ST_RUN: begin
          obst_n  = obst_step;
          phase_n = phase_step;
          rex_n   = rex_step;
          if (hit) begin
            state_n = ST_OVER;
          end else begin
            score_n = score_inc;
          end
        end
        ST_OVER: begin
          if (press) begin
            state_n = ST_IDLE;
            phase_n = 5'd0;
            rex_n   = '0;
            obst_n  = SCREEN_V;
            score_n = '0;
          end
        end
        default: begin
          state_n = ST_IDLE;
        end
      endcase
    end
  end

  // ---- stage: registered game variables ----
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= ST_IDLE;
      phase         <= 5'd0;
      rex_down      <= '0;
      obstacle_left <= SCREEN_V;
      score_o       <= '0;
    end else begin
      state         <= state_n;
      phase         <= phase_n;
      rex_down      <= rex_n;
      obstacle_left <= obst_n;
      score_o       <= score_n;
    end
  end

  assign game_state = state;

endmodule

// File: doc/rex_game_ctrl.md
# rex_game_ctrl

Game-logic controller for the Rex runner. Steps the game once per frame tick (the 12 Hz divider output) and produces the registered game variables that the renderer (Decider) consumes: rex vertical offset, obstacle column and game state. It replaces the debug constants driven today: rex_down = 0, obstacle_left = 55, game_state = 2'b00. It also runs the IDLE/RUN/OVER sequencing, jump arc, obstacle scrolling, collision detection and score counting.

## Interface
- SCREEN_W, 128: obstacle spawn/wrap column, in pixels.
- SPEED, 2: obstacle pixels moved per tick (base speed).
- MAX_SPEED, 6: speed ceiling, used only with speed-up enabled.
- REX_X, 8: rex left column.
- REX_W, 16: rex width.
- OBST_W, 4: obstacle width.
- OBST_H, 16: obstacle height; the rex clears it when rex_down >= OBST_H.
- JUMP_PEAK, 6: ticks from take-off to apex.
- JUMP_STEP, 8: height gained per tick while rising.

Ports:
- clk  in  1  system clock, 120 kHz.
- rstn  in  1  asynchronous active-low reset.
- tick_i  in  1  frame-step pulse, one clk wide, synchronous to clk.
- jump_i  in  1  jump/start button, asynchronous level.
- rex_down  out  16  rex height above ground in pixels; 0 = on ground.
- obstacle_left  out  16  obstacle left-edge column.
- game_state  out  2  00 = IDLE, 01 = RUN, 10 = OVER. The value 11 is never driven.
- score_o  out  16  number of completed RUN ticks, saturating.

## Operation
- Button input:
  - jump_i passes through a 2-flop synchronizer, then a rising-edge detector.
  - A detected edge sets the `press` flag.
  - `press` is cleared on the next tick_i.
- IDLE state:
  - Outputs hold their reset values.
  - A tick with `press` set moves to RUN. No motion occurs on that tick.
- RUN state: on each tick, the next values are computed from the current ones.
  - Obstacle: if obstacle_left < speed, it becomes SCREEN_W; otherwise it becomes obstacle_left - speed. The wrap replaces the subtraction on that tick.
  - Jump start: if on ground (phase = 0) and `press` is set, phase becomes 1.
  - Jump progress: if phase > 0, phase increments. When it would reach 2*JUMP_PEAK + 1, it returns to 0 (landed).
  - Height: rex_down = JUMP_STEP * min(phase, 2*JUMP_PEAK - phase). Phase 0 gives 0.
  - A press while airborne is consumed and ignored.
- Collision is evaluated on the next values: (obst < REX_X + REX_W) AND (obst + OBST_W > REX_X) AND (rex_down < OBST_H).
  - Collision: game_state becomes OVER, the next positions are registered, and score is unchanged.
  - No collision: score increments, saturating at 16'hFFFF.
- OVER state:
  - All outputs are frozen.
  - A tick with `press` set moves to IDLE and reloads the reset values.
- Arithmetic: 16-bit unsigned, compared without wrap-around. Phase is a 5-bit counter.

## Timing
- Reset (async, rstn low) values:
  - game_state = 00, obstacle_left = SCREEN_W, rex_down = 0, score_o = 0.
  - phase = 0, press = 0, speed = SPEED, synchronizers = 0.
- All outputs are registered and update only on the clk edge where tick_i = 1. Latency is 1 clk from tick_i.
- Button path: from jump_i rising to `press` set is 3 clk (2-flop sync plus edge detect). A press arriving in the same cycle as tick_i applies to the following tick.
- If reset is asserted mid-jump or in OVER, everything returns to reset values immediately. No partial state survives.
- Simultaneous wrap and collision cannot occur at default parameters. If it does occur, collision is evaluated on the wrapped value.

## Configuration
- REX_SPEEDUP_EN defined: on each non-colliding RUN tick where the new score[5:0] == 0, speed increments, capped at MAX_SPEED. Speed is reset to SPEED on reset and on OVER→IDLE.
- REX_SPEEDUP_EN undefined: speed is the constant SPEED. MAX_SPEED is unused.

## Test plan
Defaults apply unless stated; REX_SPEEDUP_EN is undefined.
- Reset, then apply 5 ticks with no press -> state 00, obstacle_left 128, rex_down 0, score_o 0 throughout.
- Press, then 1 tick, then 10 ticks -> state 01, obstacle_left 108, score_o 10, rex_down 0.
- Start RUN and never press -> the 52nd RUN tick gives obstacle 24, score 52; the 53rd tick gives obstacle 22, state 10, score stays 52. Further ticks do not change any output.
- Start RUN, then press after the 51st RUN tick (obstacle 26) -> rex_down sequence 8,16,24,32,40,48,40,32,24,16,8,0 over the next 12 ticks. No collision; obstacle 2 → 0 → 128 (wrap); score 63 after those 12 ticks.
- In OVER, press then tick -> state 00 with all reset values. Assert rstn low mid-jump (rex_down 40) -> all outputs reach reset values with no clk edge required.
- With REX_SPEEDUP_EN defined and a jump timed for each obstacle -> speed is 3 after score reaches 64 (obstacle steps by 3). Speed never exceeds 6.
